hangman_control: RTL
====================

# hangman_control

Game sequencer for the hangman datapath. It owns the round-level state machine, issues one-hot phase strobes (`ld`, `ld_g`, `compare`, `fill`, `draw`, `over`, `timecount`) and advances on the datapath's done/status flags. It also keeps the word length, remaining-letter count, drawn-part count and both player scores. It sits between the keyboard front end and the datapath/VGA drawing path.

## Interface
- `MAX_LEN`, 16: maximum word letters.
- `MAX_PARTS`, 6: body parts before loss; must be at most 7.
- `LW`, `$clog2(MAX_LEN+1)`: width of the length and count fields.
---
- `clk` in 1: system clock.
- `resetn` in 1: synchronous, active-high reset (despite the name).
- `key_valid` in 1: one-cycle strobe; setter typed a letter.
- `key_enter` in 1: one-cycle strobe; setter finished the word.
- `guess_valid` in 1: one-cycle strobe; guesser typed a letter.
- `guess` in 5: guessed letter code, 1–26.
- `graph_loaded` in 1: gallows drawing done.
- `finish` in 1: current dash, fill or part drawing done.
- `cmp_done` in 1: compare pass over the word complete.
- `match_cnt` in LW: number of positions matched, valid with `cmp_done`.
- `timeout` in 1: guess timer expired.
- `clear_done` in 1: screen wipe complete.
- `ld`, `ld_g`, `compare`, `fill`, `draw`, `over`, `timecount` out 1 each: phase strobes.
- `word_len` out LW: letters entered.
- `remaining` out LW: letters still hidden.
- `part` out 3: parts drawn.
- `p1score`, `p2score` out 4 each: setter and guesser scores.
- `win`, `lose` out 1 each: one-cycle pulses.
- `dup_guess` out 1: one-cycle pulse; repeated letter rejected.

## Operation
States and their asserted outputs:
- **LOAD_WORD** (`ld`):
  - `key_valid` increments `word_len`; it saturates at MAX_LEN, so extra letters are ignored.
  - `key_enter` with `word_len` ≥ 1 → LOAD_GRAPH and loads `remaining` = `word_len`. `key_enter` with `word_len` = 0 is ignored.
  - `key_valid` and `key_enter` in the same cycle: count the letter first, then evaluate the enter against the new length.
- **LOAD_GRAPH** (`ld_g`): `graph_loaded` → DRAW_DASH.
- **DRAW_DASH** (`ld`): `finish` → WAIT_GUESS.
- **WAIT_GUESS** (`timecount`):
  - `timeout` → LOSE. If `timeout` and `guess_valid` arrive together, `timeout` wins.
  - Otherwise `guess_valid` → COMPARE.
- **COMPARE** (`compare`): on `cmp_done`:
  - `match_cnt` > 0 → FILL, and `remaining` -= `match_cnt`, saturating at 0.
  - `match_cnt` = 0 → DRAW_PART, and `part` += 1.
- **FILL** (`fill`) / **DRAW_PART** (`draw`): `finish` → CHECK.
- **CHECK** (no strobe, one cycle):
  - `remaining` = 0 → WIN.
  - Else `part` = MAX_PARTS → LOSE.
  - Else → WAIT_GUESS.
- **WIN**: pulse `win`, `p2score` += 1 → GAME_OVER.
- **LOSE**: pulse `lose`, `p1score` += 1 → GAME_OVER.
- **GAME_OVER** (`over`): `clear_done` → LOAD_WORD, clearing `word_len`, `remaining` and `part`. Scores persist.

Further rules:
- Scores wrap modulo 16.
- Done inputs arriving in states that do not expect them are ignored.

## Timing
- Reset value of every output is 0. The state resets to LOAD_WORD, so `ld` reads 1 in the first cycle after reset.
- State is registered. Strobes are Moore outputs decoded from the state register: high in every cycle of their state, low in the cycle after the exiting event.
- An event sampled at edge N changes state and counters at edge N; the new strobes are visible after edge N.
- Latency from `finish` in FILL to `timecount` is 2 cycles (through CHECK).
- `resetn` asserted mid-game: aborts at the next edge, with all counters and scores cleared.

## Configuration
- `HANGMAN_GUESS_FILTER_EN` defined:
  - A 26-bit used-letter mask, cleared in LOAD_WORD, records every accepted guess.
  - A `guess_valid` for a letter already in the mask stays in WAIT_GUESS and pulses `dup_guess`.
  - A `guess` outside 1–26 is treated as a duplicate.
- Undefined: every `guess_valid` enters COMPARE, and `dup_guess` is tied to 0.

## Structure
- `hangman_pkg` holds:
  - the state enum;
  - `MAX_PARTS_DEF` and `LETTERS` = 26;
  - VGA colour constants (white, blue, red, green, black) shared with the datapath.
- One sub-module, `guess_history`: the mask plus the duplicate check, instantiated only under the macro.

## Test plan
- Reset, then `key_valid` ×3, then `key_enter`: `word_len`=3 and `remaining`=3; `ld_g` rises; `graph_loaded` then `finish` lead to `timecount` = 1.
- `key_enter` with 0 letters: stays in LOAD_WORD. 17 `key_valid` pulses: `word_len`=16.
- Word length 3; guesses return `match_cnt` 2 then 1, each followed by `finish`: `remaining` 3→1→0, `win` pulses, `p2score`=1, `over` is held until `clear_done`.
- Six guesses with `match_cnt`=0: `part` 1..6, then `lose` and `p1score`=1. `timeout` and `guess_valid` in the same cycle: LOSE.
- Under the macro: `guess`=5 twice. The second attempt pulses `dup_guess`, `compare` stays 0, and `part` is unchanged.
- `resetn` during FILL: next cycle all outputs 0 except `ld`=1, and scores are 0.

Source files
------------

// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman game sequencer and datapath.
package hangman_pkg;

    localparam int unsigned MAX_PARTS_DEF = 6;
    localparam int unsigned LETTERS       = 26;
    localparam int unsigned LETTER_W      = 5;
    localparam int unsigned PART_W        = 3;
    localparam int unsigned SCORE_W       = 4;
    localparam int unsigned COLOUR_W      = 3;

    localparam logic [COLOUR_W-1:0] COL_WHITE = 3'b111;
    localparam logic [COLOUR_W-1:0] COL_BLUE  = 3'b001;
    localparam logic [COLOUR_W-1:0] COL_RED   = 3'b100;
    localparam logic [COLOUR_W-1:0] COL_GREEN = 3'b010;
    localparam logic [COLOUR_W-1:0] COL_BLACK = 3'b000;

    typedef enum logic [3:0] {
        ST_LOAD_WORD,
        ST_LOAD_GRAPH,
        ST_DRAW_DASH,
        ST_WAIT_GUESS,
        ST_COMPARE,
        ST_FILL,
        ST_DRAW_PART,
        ST_CHECK,
        ST_WIN,
        ST_LOSE,
        ST_GAME_OVER
    } state_e;

    typedef struct packed {
        logic ld;
        logic ld_g;
        logic compare;
        logic fill;
        logic draw;
        logic over;
        logic timecount;
        logic win;
        logic lose;
    } strobe_t;

    // Moore decode of the phase strobes for a given state.
    function automatic strobe_t decode_strobes(state_e st);
        strobe_t s;
        s = '0;
        case (st)
            ST_LOAD_WORD:  s.ld        = 1'b1;
            ST_LOAD_GRAPH: s.ld_g      = 1'b1;
            ST_DRAW_DASH:  s.ld        = 1'b1;
            ST_WAIT_GUESS: s.timecount = 1'b1;
            ST_COMPARE:    s.compare   = 1'b1;
            ST_FILL:       s.fill      = 1'b1;
            ST_DRAW_PART:  s.draw      = 1'b1;
            ST_WIN:        s.win       = 1'b1;
            ST_LOSE:       s.lose      = 1'b1;
            ST_GAME_OVER:  s.over      = 1'b1;
            default:       s           = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hangman_control_guess_history.sv
// Used-letter mask and duplicate-guess detection (built only with HANGMAN_GUESS_FILTER_EN).
module guess_history
    import hangman_pkg::*;
(
    input  logic                clk,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                check_i,
    input  logic [LETTER_W-1:0] guess_i,
    output logic                dup_c
);

    logic [LETTERS-1:0] mask_q;
    logic [LETTERS-1:0] mask_d;
    logic [LETTERS-1:0] sel;
    logic               in_range;

    // Codes outside 1..26 select nothing and are rejected as duplicates.
    assign in_range = (guess_i >= LETTER_W'(1)) && (guess_i <= LETTER_W'(LETTERS));
    assign sel      = LETTERS'(1) << (guess_i - LETTER_W'(1));
    assign dup_c    = !in_range || (|(mask_q & sel));

    always_comb begin
        mask_d = mask_q;
        if (clear_i) begin
            mask_d = '0;
        end else if (check_i && !dup_c) begin
            mask_d = mask_q | sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

endmodule

// File: rtl/hangman_control.sv
// Round-level sequencer for the hangman datapath: phase strobes, word/letter/part counters, scores.
// Optional repeated-letter filter enabled by defining HANGMAN_GUESS_FILTER_EN.
module hangman_control
    import hangman_pkg::*;
#(
    parameter int unsigned MAX_LEN   = 16,
    parameter int unsigned MAX_PARTS = MAX_PARTS_DEF,
    parameter int unsigned LW        = $clog2(MAX_LEN + 1)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                key_valid,
    input  logic                key_enter,
    input  logic                guess_valid,
    input  logic [LETTER_W-1:0] guess,
    input  logic                graph_loaded,
    input  logic                finish,
    input  logic                cmp_done,
    input  logic [LW-1:0]       match_cnt,
    input  logic                timeout,
    input  logic                clear_done,
    output logic                ld,
    output logic                ld_g,
    output logic                compare,
    output logic                fill,
    output logic                draw,
    output logic                over,
    output logic                timecount,
    output logic [LW-1:0]       word_len,
    output logic [LW-1:0]       remaining,
    output logic [PART_W-1:0]   part,
    output logic [SCORE_W-1:0]  p1score,
    output logic [SCORE_W-1:0]  p2score,
    output logic                win,
    output logic                lose,
    output logic                dup_guess
);

    state_e               state_q, state_d;
    strobe_t              strobe_q, strobe_d;
    logic [LW-1:0]        word_len_q, word_len_d;
    logic [LW-1:0]        remaining_q, remaining_d;
    logic [LW-1:0]        len_inc;
    logic [PART_W-1:0]    part_q, part_d;
    logic [SCORE_W-1:0]   p1score_q, p1score_d;
    logic [SCORE_W-1:0]   p2score_q, p2score_d;
    logic                 dup_q, dup_d;
    logic                 guess_dup_c;

`ifdef HANGMAN_GUESS_FILTER_EN
    logic guess_check;

    // Timeout has priority, so a guess arriving with it is never recorded.
    assign guess_check = (state_q == ST_WAIT_GUESS) && guess_valid && !timeout;

    guess_history u_guess_history (
        .clk     (clk),
        .rst_i   (resetn),
        .clear_i (state_q == ST_LOAD_WORD),
        .check_i (guess_check),
        .guess_i (guess),
        .dup_c   (guess_dup_c)
    );
`else
    logic unused_guess;

    assign guess_dup_c  = 1'b0;
    assign unused_guess = ^guess;
`endif

    always_comb begin
        state_d     = state_q;
        word_len_d  = word_len_q;
        remaining_d = remaining_q;
        part_d      = part_q;
        p1score_d   = p1score_q;
        p2score_d   = p2score_q;
        dup_d       = 1'b0;
        len_inc     = word_len_q;

        case (state_q)
            ST_LOAD_WORD: begin
                // A letter typed together with enter counts before the enter is judged.
                if (key_valid && (word_len_q < LW'(MAX_LEN))) begin
                    len_inc = word_len_q + LW'(1);
                end
                word_len_d = len_inc;
                if (key_enter && (len_inc != '0)) begin
                    remaining_d = len_inc;
                    state_d     = ST_LOAD_GRAPH;
                end
            end
            ST_LOAD_GRAPH: if (graph_loaded) state_d = ST_DRAW_DASH;
            ST_DRAW_DASH:  if (finish)       state_d = ST_WAIT_GUESS;
            ST_WAIT_GUESS: begin
                if (timeout) begin
                    state_d = ST_LOSE;
                end else if (guess_valid) begin
                    if (guess_dup_c) begin
                        dup_d = 1'b1;
                    end else begin
                        state_d = ST_COMPARE;
                    end
                end
            end
            ST_COMPARE: begin
                if (cmp_done) begin
                    if (match_cnt != '0) begin
                        remaining_d = (match_cnt >= remaining_q) ? '0 : remaining_q - match_cnt;
                        state_d     = ST_FILL;
                    end else begin
                        part_d  = part_q + PART_W'(1);
                        state_d = ST_DRAW_PART;
                    end
                end
            end
            ST_FILL, ST_DRAW_PART: if (finish) state_d = ST_CHECK;
            ST_CHECK: begin
                if (remaining_q == '0) begin
                    state_d = ST_WIN;
                end else if (part_q == PART_W'(MAX_PARTS)) begin
                    state_d = ST_LOSE;
                end else begin
                    state_d = ST_WAIT_GUESS;
                end
            end
            ST_WIN: begin
                p2score_d = p2score_q + SCORE_W'(1);
                state_d   = ST_GAME_OVER;
            end
            ST_LOSE: begin
                p1score_d = p1score_q + SCORE_W'(1);
                state_d   = ST_GAME_OVER;
            end
            ST_GAME_OVER: begin
                if (clear_done) begin
                    word_len_d  = '0;
                    remaining_d = '0;
                    part_d      = '0;
                    state_d     = ST_LOAD_WORD;
                end
            end
            default: state_d = ST_LOAD_WORD;
        endcase

        strobe_d = decode_strobes(state_d);
    end

    // Strobes are registered from the next state so they track the state register exactly.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q     <= ST_LOAD_WORD;
            strobe_q    <= decode_strobes(ST_LOAD_WORD);
            word_len_q  <= '0;
            remaining_q <= '0;
            part_q      <= '0;
            p1score_q   <= '0;
            p2score_q   <= '0;
            dup_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            strobe_q    <= strobe_d;
            word_len_q  <= word_len_d;
            remaining_q <= remaining_d;
            part_q      <= part_d;
            p1score_q   <= p1score_d;
            p2score_q   <= p2score_d;
            dup_q       <= dup_d;
        end
    end

    assign ld        = strobe_q.ld;
    assign ld_g      = strobe_q.ld_g;
    assign compare   = strobe_q.compare;
    assign fill      = strobe_q.fill;
    assign draw      = strobe_q.draw;
    assign over      = strobe_q.over;
    assign timecount = strobe_q.timecount;
    assign win       = strobe_q.win;
    assign lose      = strobe_q.lose;
    assign dup_guess = dup_q;
    assign word_len  = word_len_q;
    assign remaining = remaining_q;
    assign part      = part_q;
    assign p1score   = p1score_q;
    assign p2score   = p2score_q;

endmodule
